// File: rtl/mmc1_pkg.sv
// Shared types and constants for the MMC1 bank controller.
package mmc1_pkg;

  typedef enum logic [1:0] {
    MirrorOneLow,
    MirrorOneHigh,
    MirrorVertical,
    MirrorHorizontal
  } mirror_e;

  typedef enum logic [1:0] {
    PrgSwitch32A,
    PrgSwitch32B,
    PrgFixFirst,
    PrgFixLast
  } prg_mode_e;

  localparam logic [1:0] REG_CONTROL = 2'd0;
  localparam logic [1:0] REG_CHR0    = 2'd1;
  localparam logic [1:0] REG_CHR1    = 2'd2;
  localparam logic [1:0] REG_PRG     = 2'd3;

  localparam logic [4:0] CTRL_RESET = 5'h0C;

endpackage

// File: rtl/mmc1_serial_loader.sv
// MMC1 serial port: write-strobe edge detect, 5-bit LSB-first shift register and bit count.
module mmc1_serial_loader (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       write_i,
  input  logic       addr_msb_i,
  input  logic       data_reset_i,
  input  logic       data_bit_i,
  output logic [2:0] count_o,
  output logic       clear_o,
  output logic       commit_o,
  output logic [4:0] commit_data_o
);

  logic       write_prev_q, write_prev_d;
  logic [3:0] shift_q, shift_d;
  logic [2:0] count_q, count_d;
  logic       accept;

  always_comb begin
    accept        = write_i & ~write_prev_q & addr_msb_i;
    write_prev_d  = write_i;
    shift_d       = shift_q;
    count_d       = count_q;
    clear_o       = 1'b0;
    commit_o      = 1'b0;
    commit_data_o = {data_bit_i, shift_q};
    if (accept) begin
      if (data_reset_i) begin
        clear_o = 1'b1;
        shift_d = '0;
        count_d = '0;
      end else if (count_q == 3'd4) begin
        commit_o = 1'b1;
        shift_d  = '0;
        count_d  = '0;
      end else begin
        // New bits enter at the top so the first bit ends up in shift_q[0].
        shift_d = {data_bit_i, shift_q[3:1]};
        count_d = count_q + 3'd1;
      end
    end
  end

  // History resets high so a strobe held through reset must fall before it counts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      write_prev_q <= 1'b1;
      shift_q      <= '0;
      count_q      <= '0;
    end else begin
      write_prev_q <= write_prev_d;
      shift_q      <= shift_d;
      count_q      <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mmc1_bank_ctrl.sv
// MMC1 mapper: serially loaded control/CHR/PRG registers and combinational address translation.
module mmc1_bank_ctrl
  import mmc1_pkg::*;
#(
  parameter int unsigned PRG_BANK_BITS = 4,
  parameter int unsigned CHR_BANK_BITS = 5
) (
  input  logic                      cart_clk_in,
  input  logic                      cart_rst_n_in,
  input  logic                      prg_write_in,
  input  logic [15:0]               prg_address_in,
  input  logic [7:0]                prg_data_in,
  input  logic [13:0]               chr_address_in,
  output logic [PRG_BANK_BITS+13:0] prg_rom_address_out,
  output logic [CHR_BANK_BITS+11:0] chr_rom_address_out,
  output logic                      cart_address_out,
  output logic                      prg_ram_enable_out,
  output logic [2:0]                shift_count_out
);

  logic [4:0] control_q, control_d;
  logic [4:0] chr0_q, chr0_d;
  logic [4:0] chr1_q, chr1_d;
  logic [4:0] prg_q, prg_d;
  logic       clear, commit;
  logic [4:0] commit_data;
  logic       unused_bits;

  logic [PRG_BANK_BITS-1:0] prg_bank;
  logic [CHR_BANK_BITS-1:0] chr_bank;
  mirror_e                  mirror;
  prg_mode_e                prg_mode;

  assign unused_bits = ^{prg_data_in[6:1], chr_address_in[13]};

  mmc1_serial_loader u_loader (
    .clk_i         (cart_clk_in),
    .rst_ni        (cart_rst_n_in),
    .write_i       (prg_write_in),
    .addr_msb_i    (prg_address_in[15]),
    .data_reset_i  (prg_data_in[7]),
    .data_bit_i    (prg_data_in[0]),
    .count_o       (shift_count_out),
    .clear_o       (clear),
    .commit_o      (commit),
    .commit_data_o (commit_data)
  );

  always_comb begin
    control_d = control_q;
    chr0_d    = chr0_q;
    chr1_d    = chr1_q;
    prg_d     = prg_q;
    if (clear) begin
      control_d = control_q | CTRL_RESET;
    end else if (commit) begin
      unique case (prg_address_in[14:13])
        REG_CONTROL: control_d = commit_data;
        REG_CHR0:    chr0_d    = commit_data;
        REG_CHR1:    chr1_d    = commit_data;
        REG_PRG:     prg_d     = commit_data;
      endcase
    end
  end

  always_ff @(posedge cart_clk_in or negedge cart_rst_n_in) begin
    if (!cart_rst_n_in) begin
      control_q <= CTRL_RESET;
      chr0_q    <= '0;
      chr1_q    <= '0;
      prg_q     <= '0;
    end else begin
      control_q <= control_d;
      chr0_q    <= chr0_d;
      chr1_q    <= chr1_d;
      prg_q     <= prg_d;
    end
  end

  // Bank values are sized to the ROM with casts: truncate when wider, zero-extend when narrower.
  always_comb begin
    mirror   = mirror_e'(control_q[1:0]);
    prg_mode = prg_mode_e'(control_q[3:2]);
    prg_bank = '0;
    unique case (prg_mode)
      PrgSwitch32A, PrgSwitch32B:
        prg_bank = PRG_BANK_BITS'({prg_q[3:1], prg_address_in[14]});
      PrgFixFirst:
        prg_bank = prg_address_in[14] ? PRG_BANK_BITS'(prg_q[3:0]) : '0;
      PrgFixLast:
        prg_bank = prg_address_in[14] ? '1 : PRG_BANK_BITS'(prg_q[3:0]);
    endcase

    if (control_q[4]) begin
      chr_bank = chr_address_in[12] ? CHR_BANK_BITS'(chr1_q) : CHR_BANK_BITS'(chr0_q);
    end else begin
      chr_bank = CHR_BANK_BITS'({chr0_q[4:1], chr_address_in[12]});
    end

    cart_address_out = 1'b0;
    unique case (mirror)
      MirrorOneLow:     cart_address_out = 1'b0;
      MirrorOneHigh:    cart_address_out = 1'b1;
      MirrorVertical:   cart_address_out = chr_address_in[10];
      MirrorHorizontal: cart_address_out = chr_address_in[11];
    endcase
  end

  assign prg_rom_address_out = {prg_bank, prg_address_in[13:0]};
  assign chr_rom_address_out = {chr_bank, chr_address_in[11:0]};
  assign prg_ram_enable_out  = ~prg_q[4] & (prg_address_in[15:13] == 3'b011);

endmodule

// File: tb/tb_mmc1_bank_ctrl.sv
// Directed self-checking bench for mmc1_bank_ctrl with default bank widths.
module tb_mmc1_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] pa = '0;
  logic [7:0]  pd = '0;
  logic [13:0] ca = '0;
  logic [17:0] prg_rom;
  logic [16:0] chr_rom;
  logic        ciram;
  logic        ram_en;
  logic [2:0]  cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mmc1_bank_ctrl #(
    .PRG_BANK_BITS (4),
    .CHR_BANK_BITS (5)
  ) dut (
    .cart_clk_in         (clk),
    .cart_rst_n_in       (rst_n),
    .prg_write_in        (wr),
    .prg_address_in      (pa),
    .prg_data_in         (pd),
    .chr_address_in      (ca),
    .prg_rom_address_out (prg_rom),
    .chr_rom_address_out (chr_rom),
    .cart_address_out    (ciram),
    .prg_ram_enable_out  (ram_en),
    .shift_count_out     (cnt)
  );

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pa = a;
    pd = d;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic load5(input logic [15:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) cpu_write(a, {7'd0, v[i]});
  endtask

  task automatic probe(input logic [15:0] a, input logic [13:0] c);
    @(negedge clk);
    pa = a;
    ca = c;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    probe(16'hC123, 14'h1ABC);
    checks++; if (prg_rom !== 18'h3C123) begin errors++; $display("FAIL reset_prg_c123: got %h want %h", prg_rom, 18'h3C123); end
    checks++; if (chr_rom !== 17'h01ABC) begin errors++; $display("FAIL reset_chr: got %h want %h", chr_rom, 17'h01ABC); end
    checks++; if (ciram !== 1'b0) begin errors++; $display("FAIL reset_ciram: got %b want 0", ciram); end
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cnt); end
    probe(16'h8123, 14'h0000);
    checks++; if (prg_rom !== 18'h00123) begin errors++; $display("FAIL reset_prg_8123: got %h want %h", prg_rom, 18'h00123); end
    probe(16'h6000, 14'h0000);
    checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL reset_ram_6000: got %b want 1", ram_en); end
    probe(16'h5FFF, 14'h0000);
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_5fff: got %b want 0", ram_en); end
  endtask

  task automatic test_prg_bank;
    cpu_write(16'hE000, 8'h01);
    cpu_write(16'hE000, 8'h00);
    cpu_write(16'hE000, 8'h01);
    cpu_write(16'hE000, 8'h00);
    checks++; if (cnt !== 3'd4) begin errors++; $display("FAIL prg_count4: got %0d want 4", cnt); end
    cpu_write(16'hE000, 8'h00);
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL prg_count_wrap: got %0d want 0", cnt); end
    probe(16'h8000, 14'h0000);
    checks++; if (prg_rom !== 18'h14000) begin errors++; $display("FAIL prg_bank5_8000: got %h want %h", prg_rom, 18'h14000); end
    probe(16'hC000, 14'h0000);
    checks++; if (prg_rom !== 18'h3C000) begin errors++; $display("FAIL prg_fixed_c000: got %h want %h", prg_rom, 18'h3C000); end
  endtask

  task automatic test_ignore_low;
    cpu_write(16'h6000, 8'h01);
    cpu_write(16'h7FFF, 8'h80);
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL low_write_ignored: got %0d want 0", cnt); end
  endtask

  task automatic test_reset_bit;
    load5(16'h8000, 5'h00);
    probe(16'h8000, 14'h0000);
    checks++; if (prg_rom !== 18'h10000) begin errors++; $display("FAIL mode32_8000: got %h want %h", prg_rom, 18'h10000); end
    probe(16'hC000, 14'h0000);
    checks++; if (prg_rom !== 18'h14000) begin errors++; $display("FAIL mode32_c000: got %h want %h", prg_rom, 18'h14000); end
    cpu_write(16'hA000, 8'h01);
    cpu_write(16'hA000, 8'h01);
    checks++; if (cnt !== 3'd2) begin errors++; $display("FAIL partial_count: got %0d want 2", cnt); end
    cpu_write(16'hA000, 8'h80);
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL clear_count: got %0d want 0", cnt); end
    probe(16'hC000, 14'h0123);
    checks++; if (prg_rom !== 18'h3C000) begin errors++; $display("FAIL clear_mode_c000: got %h want %h", prg_rom, 18'h3C000); end
    checks++; if (chr_rom !== 17'h00123) begin errors++; $display("FAIL clear_chr0_kept: got %h want %h", chr_rom, 17'h00123); end
    probe(16'h8000, 14'h0123);
    checks++; if (prg_rom !== 18'h14000) begin errors++; $display("FAIL clear_prg_kept: got %h want %h", prg_rom, 18'h14000); end
    load5(16'hA000, 5'h03);
    probe(16'h8000, 14'h0123);
    checks++; if (chr_rom !== 17'h02123) begin errors++; $display("FAIL chr0_after_clear: got %h want %h", chr_rom, 17'h02123); end
  endtask

  task automatic test_held_write;
    @(negedge clk);
    pa = 16'hE000;
    pd = 8'h01;
    wr = 1'b1;
    repeat (10) @(negedge clk);
    wr = 1'b0;
    checks++; if (cnt !== 3'd1) begin errors++; $display("FAIL held_strobe_count: got %0d want 1", cnt); end
    for (int i = 0; i < 4; i++) cpu_write(16'hE000, 8'h00);
    probe(16'h8000, 14'h0000);
    checks++; if (prg_rom !== 18'h04000) begin errors++; $display("FAIL held_prg_bank1: got %h want %h", prg_rom, 18'h04000); end
  endtask

  task automatic test_chr_mode;
    load5(16'h8000, 5'h12);
    load5(16'hC000, 5'h07);
    probe(16'hC000, 14'h1ABC);
    checks++; if (chr_rom !== 17'h07ABC) begin errors++; $display("FAIL chr4k_1abc: got %h want %h", chr_rom, 17'h07ABC); end
    checks++; if (ciram !== 1'b0) begin errors++; $display("FAIL vert_1abc: got %b want 0", ciram); end
    checks++; if (prg_rom !== 18'h04000) begin errors++; $display("FAIL mode32_bank1_c000: got %h want %h", prg_rom, 18'h04000); end
    probe(16'hC000, 14'h0400);
    checks++; if (chr_rom !== 17'h03400) begin errors++; $display("FAIL chr4k_0400: got %h want %h", chr_rom, 17'h03400); end
    checks++; if (ciram !== 1'b1) begin errors++; $display("FAIL vert_0400: got %b want 1", ciram); end
    load5(16'h8000, 5'h0B);
    probe(16'hC456, 14'h0800);
    checks++; if (prg_rom !== 18'h04456) begin errors++; $display("FAIL fixfirst_c456: got %h want %h", prg_rom, 18'h04456); end
    checks++; if (ciram !== 1'b1) begin errors++; $display("FAIL horiz_0800: got %b want 1", ciram); end
    checks++; if (chr_rom !== 17'h02800) begin errors++; $display("FAIL chr8k_0800: got %h want %h", chr_rom, 17'h02800); end
    probe(16'h8456, 14'h0400);
    checks++; if (prg_rom !== 18'h00456) begin errors++; $display("FAIL fixfirst_8456: got %h want %h", prg_rom, 18'h00456); end
    checks++; if (ciram !== 1'b0) begin errors++; $display("FAIL horiz_0400: got %b want 0", ciram); end
    load5(16'h8000, 5'h0D);
    probe(16'h8000, 14'h0000);
    checks++; if (ciram !== 1'b1) begin errors++; $display("FAIL onescreen_high: got %b want 1", ciram); end
    probe(16'h7FFF, 14'h0000);
    checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL ram_7fff: got %b want 1", ram_en); end
    load5(16'hE000, 5'h10);
    probe(16'h6000, 14'h0000);
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL ram_disabled: got %b want 0", ram_en); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) cpu_write(16'hE000, 8'h01);
    checks++; if (cnt !== 3'd3) begin errors++; $display("FAIL mid_count3: got %0d want 3", cnt); end
    #2;
    rst_n = 1'b0;
    pa = 16'h6000;
    #1;
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL mid_async_count: got %0d want 0", cnt); end
    checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL mid_async_ram: got %b want 1", ram_en); end
    @(negedge clk);
    rst_n = 1'b1;
    probe(16'hC123, 14'h1ABC);
    checks++; if (prg_rom !== 18'h3C123) begin errors++; $display("FAIL mid_prg_c123: got %h want %h", prg_rom, 18'h3C123); end
    checks++; if (chr_rom !== 17'h01ABC) begin errors++; $display("FAIL mid_chr: got %h want %h", chr_rom, 17'h01ABC); end
    checks++; if (ciram !== 1'b0) begin errors++; $display("FAIL mid_ciram: got %b want 0", ciram); end
    load5(16'hE000, 5'h06);
    probe(16'h8000, 14'h0000);
    checks++; if (prg_rom !== 18'h18000) begin errors++; $display("FAIL mid_reload: got %h want %h", prg_rom, 18'h18000); end
  endtask

  task automatic test_held_strobe_reset;
    @(negedge clk);
    pa = 16'hE000;
    pd = 8'h01;
    wr = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL held_through_reset: got %0d want 0", cnt); end
    wr = 1'b0;
    cpu_write(16'hE000, 8'h01);
    checks++; if (cnt !== 3'd1) begin errors++; $display("FAIL after_fall_rise: got %0d want 1", cnt); end
  endtask

  initial begin
    test_reset();
    test_prg_bank();
    test_ignore_low();
    test_reset_bit();
    test_held_write();
    test_chr_mode();
    test_reset_mid();
    test_held_strobe_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmc1_bank_ctrl.md
MMC1_BANK_CTRL -- requirements
Module: mmc1_bank_ctrl

Interface
REQ-001 SHALL have parameter PRG_BANK_BITS, default 4, giving the 16 KB PRG bank index width (256 KB ROM).
REQ-002 SHALL have parameter CHR_BANK_BITS, default 5, giving the 4 KB CHR bank index width (128 KB ROM).
REQ-003 SHALL have port cart_clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port cart_rst_n_in, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port prg_write_in, input, 1 bit: CPU write strobe; level, may be held for several clocks.
REQ-006 SHALL have port prg_address_in, input, 16 bits: CPU address.
REQ-007 SHALL have port prg_data_in, input, 8 bits: CPU write data.
REQ-008 SHALL have port chr_address_in, input, 14 bits: PPU address.
REQ-009 SHALL have port prg_rom_address_out, output, PRG_BANK_BITS+14 bits: translated PRG ROM address.
REQ-010 SHALL have port chr_rom_address_out, output, CHR_BANK_BITS+12 bits: translated CHR ROM address.
REQ-011 SHALL have port cart_address_out, output, 1 bit: CIRAM A10 (nametable select).
REQ-012 SHALL have port prg_ram_enable_out, output, 1 bit: PRG RAM select for $6000-$7FFF.
REQ-013 SHALL have port shift_count_out, output, 3 bits: number of serial bits loaded so far (0-4).

Function
REQ-014 SHALL accept a write only on a clock where prg_write_in=1, the prior sampled prg_write_in=0, and prg_address_in[15]=1; a held strobe SHALL count once.
REQ-015 SHALL, on an accepted write with prg_data_in[7]=1, clear the shift register and count to 0 and OR 0x0C into control, in the same edge.
REQ-016 SHALL, on an accepted write with prg_data_in[7]=0, shift prg_data_in[0] into the shift register LSB-first and increment the count.
REQ-017 SHALL, on the 5th accepted bit, commit {bit, shift[3:0]} to the register selected by prg_address_in[14:13] (0 control, 1 chr0, 2 chr1, 3 prg), then clear the count to 0 in the same edge.
REQ-018 SHALL make committed register values visible on all outputs from the clock after the committing edge; address translation SHALL otherwise be combinational.
REQ-019 SHALL drive cart_address_out from control[1:0]: 0 -> 0, 1 -> 1, 2 -> chr_address_in[10] (vertical), 3 -> chr_address_in[11] (horizontal).
REQ-020 SHALL form prg_rom_address_out as {bank, prg_address_in[13:0]}, with bank selected by control[3:2]: 0/1 -> {prg[3:1], prg_address_in[14]}; 2 -> 0 if addr[14]=0, else prg[3:0]; 3 -> prg[3:0] if addr[14]=0, else all-ones.
REQ-021 SHALL form chr_rom_address_out as {bank, chr_address_in[11:0]}, with bank selected by control[4]: 0 -> {chr0[4:1], chr_address_in[12]}; 1 -> chr_address_in[12] ? chr1 : chr0.
REQ-022 SHALL truncate bank values wider than the bank width to its LSBs, and zero-extend narrower ones.
REQ-023 SHALL assert prg_ram_enable_out only when prg[4]=0 and prg_address_in is in $6000-$7FFF.
REQ-024 SHALL ignore writes below $8000 for all register state.

Reset
REQ-025 SHALL, while cart_rst_n_in=0, immediately set control=0x0C, chr0=0, chr1=0, prg=0, shift=0, count=0 and the write-edge history to 1; a partial serial load SHALL be discarded.
REQ-026 SHALL ensure a write strobe already high when reset releases is not accepted until it falls and rises again.

Structure
REQ-027 SHALL place in package mmc1_pkg: the mirroring and PRG-mode enums, the register-select constants, and CTRL_RESET=0x0C.
REQ-028 SHALL place the edge detect, shift register and count in sub-module mmc1_serial_loader, which emits a commit pulse with 5-bit data.

Verification
REQ-029 SHALL cover: after reset, CPU $C000 with addr offset 0x123 -> prg_rom_address_out = 0x3C123 (last bank fixed).
REQ-030 SHALL cover: five writes to $E000 with data bits 1,0,1,0,0 (value 5) -> bank 5 at $8000 (0x14000 base) and $C000 still 0x3C000.
REQ-031 SHALL cover: two bits loaded, then a write of 0x80 -> shift_count_out=0, control[3:2]=3, other registers unchanged.
REQ-032 SHALL cover: prg_write_in held high for 10 clocks on one write -> shift_count_out increments by exactly 1.
REQ-033 SHALL cover: control value 0x12 (CHR 4 KB mode, mirror 2), chr1=7 -> PPU $1ABC maps to chr_rom_address_out 0x07ABC, and cart_address_out = chr_address_in[10].
REQ-034 SHALL cover: reset asserted after 3 bits are loaded -> all registers return to reset values, and the next 5 bits commit normally.
